// File: rtl/uart_tx_param_if.sv
// Upstream word handshake between the capture FIFO and the serial transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Data;
  logic                 Valid;
  logic                 Ready;
  logic                 RdCLK;

  modport master (output Data, output Valid, input Ready, input RdCLK);
  modport slave  (input Data, input Valid, output Ready, output RdCLK);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB first, optional parity,
// stop bits and optional idle gap, paced by an internal baud counter.
module uart_tx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned GAP_BITS     = 0
) (
  input  logic             SendingCLK,
  input  logic             nRST,
  input  logic             Init,
  input  logic             EN,
  uart_tx_param_if.slave   bus,
  output logic             Tx,
  output logic             Busy
);
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 bit_end;
  logic                 last_cycle;
  logic                 accept;

  assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Final cycle of the frame tail: lets the next word start with no idle gap.
  always_comb begin
    last_cycle = 1'b0;
    if (bit_end) begin
      if (GAP_BITS == 0) last_cycle = (state == S_STOP) && (bit_cnt == BIT_W'(STOP_BITS - 1));
      else               last_cycle = (state == S_GAP)  && (bit_cnt == BIT_W'(GAP_BITS - 1));
    end
  end

  assign bus.Ready = nRST && ((state == S_IDLE) || last_cycle) && EN && !Init;
  assign accept    = bus.Valid && bus.Ready;

  // Tx is loaded with the value of the bit being entered, so it is registered
  // and changes on the same edge as the state.
  always_ff @(posedge SendingCLK or negedge nRST) begin
    if (!nRST) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      Tx        <= 1'b1;
      Busy      <= 1'b0;
      bus.RdCLK <= 1'b0;
    end else if (Init) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      Tx        <= 1'b1;
      Busy      <= 1'b0;
      bus.RdCLK <= 1'b0;
    end else begin
      bus.RdCLK <= accept;
      if (accept) begin
        state    <= S_START;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        shift_q  <= bus.Data;
        parity_q <= (PARITY == 1) ? ~^bus.Data : ^bus.Data;
        Tx       <= 1'b0;
        Busy     <= 1'b1;
      end else if (state != S_IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          case (state)
            S_START: begin
              state   <= S_DATA;
              bit_cnt <= '0;
              Tx      <= shift_q[0];
            end
            S_DATA: begin
              if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                if (PARITY != 0) begin
                  state <= S_PARITY;
                  Tx    <= parity_q;
                end else begin
                  state <= S_STOP;
                  Tx    <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shift_q <= shift_q >> 1;
                Tx      <= shift_q[1];
              end
            end
            S_PARITY: begin
              state   <= S_STOP;
              bit_cnt <= '0;
              Tx      <= 1'b1;
            end
            S_STOP: begin
              if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                bit_cnt <= '0;
                if (GAP_BITS != 0) begin
                  state <= S_GAP;
                end else begin
                  state <= S_IDLE;
                  Busy  <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            S_GAP: begin
              if (bit_cnt == BIT_W'(GAP_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= S_IDLE;
                Busy    <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            default: begin
              state <= S_IDLE;
              Tx    <= 1'b1;
              Busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end
endmodule
